cla_wide_add_seq: RTL and testbench
===================================

# cla_wide_add_seq

Multi-cycle sequencer that performs NWORDS×16-bit additions and subtractions using one external 16-bit carry-lookahead adder. Operands are accepted through a valid/ready handshake. The sequencer drives the adder one 16-bit slice per cycle, least-significant slice first, and feeds each slice's carry-out into the next slice. It returns the full-width result through a second valid/ready handshake. It sits between the wide-arithmetic requester and the shared 16-bit `adder_CLA` instance, which is wired combinationally in the loop.

## Interface
Parameters:
- NWORDS, default 4: number of 16-bit slices; operand width is 16*NWORDS; legal range 2..16.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  sequencer can accept; equals (state==IDLE).
- in_a  in  16*NWORDS  operand A.
- in_b  in  16*NWORDS  operand B.
- in_cin  in  1  carry-in to slice 0.
- in_sub  in  1  1 = compute A−B (see Configuration).
- add_a  out  16  slice of A to the adder.
- add_b  out  16  slice of effective B to the adder.
- add_cin  out  1  carry into the adder.
- add_s  in  16  adder sum, combinational from add_a, add_b and add_cin.
- add_cout  in  1  adder carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  16*NWORDS  result.
- out_cout  out  1  final carry-out; for subtraction, 1 = no borrow.
- out_ovf  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. Slice index idx has width ceil(log2(NWORDS)).
- IDLE: in_ready=1.
  - When in_valid is 1, latch in_a into opa.
  - Latch the effective B into opb: ~in_b if subtracting, else in_b.
  - Latch the carry register: in_cin | subtracting.
  - Clear idx to 0 and go to RUN.
- RUN:
  - add_a = opa[16*idx +: 16], add_b = opb[16*idx +: 16], add_cin = carry.
  - At each edge, write add_s into sum[16*idx +: 16], load carry with add_cout and increment idx.
  - When idx == NWORDS−1, go to DONE instead of incrementing idx.
- DONE:
  - out_valid=1. out_sum = sum; out_cout = carry.
  - out_ovf = (opa_msb == opb_msb) && (sum_msb != opa_msb), where opb is the effective B.
  - When out_ready is 1, go to IDLE.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- Arithmetic is modulo 2^(16*NWORDS). The carry out of the top slice goes only to out_cout.
- in_valid is ignored outside IDLE. The requester holds the request until in_ready is 1.

## Timing
- Reset (rst_n low, takes effect immediately):
  - state=IDLE, idx=0, carry=0, sum=0, opa=opb=0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - add_* outputs = 0.
  - in_ready=1 while rst_n is low and after it rises.
- Reset during RUN or DONE aborts the operation. The result is discarded and nothing is emitted.
- Latency: the request is accepted at edge E. Edges E+1..E+NWORDS process slices 0..NWORDS−1. out_valid is 1 in the cycle after edge E+NWORDS.
- out_valid, out_sum, out_cout and out_ovf stay stable until the edge where out_ready is 1. out_valid is 0 in the next cycle.
- in_ready rises in the cycle after the result handshake. Peak throughput is one operation per NWORDS+2 cycles.
- out_ready is sampled only in DONE.
- The external adder must settle within one clk period, since the adder loop is combinational.

## Configuration
- Macro ADDSEQ_SUB_EN.
- Defined: in_sub=1 selects subtraction; effective B = ~in_b and carry-in = 1, and in_cin is ignored.
- Undefined: in_sub is ignored and treated as 0; the inversion logic is not built. The port remains so the interface is identical in both builds.

## Test plan
NWORDS=4 unless stated.
- Carry ripple: 0x0000_0000_0000_FFFF + 0x1, cin=0 → sum 0x0000_0000_0001_0000, cout=0, ovf=0; out_valid 4 cycles after acceptance.
- Full wrap: 0xFFFF_FFFF_FFFF_FFFF + 0x1 → sum 0, cout=1, ovf=0. Check add_cin=1 in the slice 1, 2 and 3 cycles.
- Signed overflow: 0x7FFF_FFFF_FFFF_FFFF + 0x1 → sum 0x8000_0000_0000_0000, cout=0, ovf=1.
- Subtract: 5 − 7, in_sub=1.
  - ADDSEQ_SUB_EN defined: sum 0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - ADDSEQ_SUB_EN undefined: sum 0xC (5 + 7), cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_* stable and in_ready=0. A second in_valid is not accepted until the cycle after the result handshake.
- Reset abort: drive rst_n low while idx=2 in RUN → out_valid=0 and in_ready=1 immediately. After release, 1+2 returns 3 with correct latency.

Source files
------------

// File: rtl/cla_wide_add_seq_if.sv
// Bus bundle for cla_wide_add_seq.
// Purpose: groups the request handshake, the response handshake and the 16-bit adder loop
//   into one interface.
// Signals:
//   in_valid/in_ready     request handshake; in_a, in_b, in_cin, in_sub carry the operands.
//   add_a/add_b/add_cin   slice presented to the external 16-bit adder.
//   add_s/add_cout        combinational adder result.
//   out_valid/out_ready   response handshake; out_sum, out_cout, out_ovf carry the result.
// Modports:
//   slave  - the sequencer.
//   master - the requester/consumer plus the external adder.
interface cla_wide_add_seq_if #(
    parameter int unsigned NWORDS = 4
);
    localparam int unsigned W = 16 * NWORDS;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_sub;

    logic [15:0]   add_a;
    logic [15:0]   add_b;
    logic          add_cin;
    logic [15:0]   add_s;
    logic          add_cout;

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, add_s, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, add_s, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/cla_wide_add_seq.sv
// cla_wide_add_seq: multi-cycle NWORDS x 16-bit add/subtract sequencer.
// Purpose: accepts a wide operand pair, drives one shared 16-bit carry-lookahead adder one
//   slice per cycle (LS slice first, carry chained through a register), and returns the
//   full-width sum, final carry and signed overflow.
// Ports:
//   clk     - clock, rising edge.
//   rst_n   - asynchronous active-low reset.
//   bus_io  - cla_wide_add_seq_if.slave: request handshake, adder loop, response handshake.
// Configuration:
//   ADDSEQ_SUB_EN - when defined, in_sub=1 computes A-B (B inverted, carry-in forced to 1,
//                   in_cin ignored). When undefined, in_sub is ignored.
module cla_wide_add_seq #(
    parameter int unsigned NWORDS = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    cla_wide_add_seq_if.slave    bus_io
);
    localparam int unsigned W    = 16 * NWORDS;
    localparam int unsigned IdxW = $clog2(NWORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [IdxW-1:0] idx_q;
    logic            carry_q;
    logic [W-1:0]    opa_q;
    logic [W-1:0]    opb_q;
    logic [W-1:0]    sum_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic            sub;
    logic [W-1:0]    eff_b;
    logic [IdxW+3:0] base;

    // Bit offset of the current slice.
    assign base = {idx_q, 4'd0};

`ifdef ADDSEQ_SUB_EN
    assign sub   = bus_io.in_sub;
    assign eff_b = sub ? ~bus_io.in_b : bus_io.in_b;
`else
    logic unused_in_sub;
    assign unused_in_sub = bus_io.in_sub;
    assign sub           = 1'b0;
    assign eff_b         = bus_io.in_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        opa_q      <= bus_io.in_a;
                        opb_q      <= eff_b;
                        // Subtraction is A + ~B + 1.
                        carry_q    <= bus_io.in_cin | sub;
                        idx_q      <= '0;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                    end
                end
                StRun: begin
                    sum_q[base +: 16] <= bus_io.add_s;
                    carry_q           <= bus_io.add_cout;
                    if (idx_q == LastIdx) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus_io.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus_io.in_ready  = in_ready_q;

    // Adder inputs are quiet outside RUN so the shared adder sees no stray activity.
    assign bus_io.add_a     = (state_q == StRun) ? opa_q[base +: 16] : 16'd0;
    assign bus_io.add_b     = (state_q == StRun) ? opb_q[base +: 16] : 16'd0;
    assign bus_io.add_cin   = (state_q == StRun) ? carry_q : 1'b0;

    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_sum   = out_valid_q ? sum_q : '0;
    assign bus_io.out_cout  = out_valid_q & carry_q;
    // Overflow uses the effective B, so it is correct for subtraction as well.
    assign bus_io.out_ovf   = out_valid_q & (opa_q[W-1] == opb_q[W-1]) &
                              (sum_q[W-1] != opa_q[W-1]);
endmodule

// File: tb/tb_cla_wide_add_seq.sv
module tb_cla_wide_add_seq;
    localparam int NWORDS = 4;
    localparam int W      = 16 * NWORDS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        string        name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_wide_add_seq_if #(.NWORDS(NWORDS)) bus ();

    cla_wide_add_seq #(.NWORDS(NWORDS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    // External 16-bit adder model.
    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 17'(bus.add_cin);

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] s, input logic c, input logic o, input int acc,
                            input string name);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.acc = acc; e.name = name;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] s, input logic c, input logic o,
                        input string name);
        bit got = 0;
        int n   = 0;
        bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub;
        bus.in_valid = 1'b1;
        while (!got && n < 50) begin
            if (bus.in_ready) begin
                got = 1;
                push_exp(s, c, o, cyc + 1, name);
            end
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_accept: in_ready never seen within 50 cycles", name);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL %s_done: result not seen within 50 cycles", name);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every result handshake.
    initial begin : monitor
        exp_t e;
        bit   seen  = 0;
        int   first = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                seen = 0;
            end else begin
                if (bus.out_valid && !seen) begin
                    seen  = 1;
                    first = cyc;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL spurious_out: got sum 0x%0h with no request pending",
                                 bus.out_sum);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_sum"}, bus.out_sum, e.sum);
                        check({e.name, "_cout"}, W'(bus.out_cout), W'(e.cout));
                        check({e.name, "_ovf"}, W'(bus.out_ovf), W'(e.ovf));
                        check({e.name, "_latency"}, W'(first - e.acc), W'(NWORDS));
                    end
                    seen = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : driver
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
        bus.in_sub = 1'b0; bus.out_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_out_sum", bus.out_sum, '0);
        check("rst_out_cout", W'(bus.out_cout), W'(0));
        check("rst_out_ovf", W'(bus.out_ovf), W'(0));
        check("rst_add_a", W'(bus.add_a), W'(0));
        check("rst_add_b", W'(bus.add_b), W'(0));
        check("rst_add_cin", W'(bus.add_cin), W'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", W'(bus.in_ready), W'(1));

        // Carry ripple from slice 0 into slice 1.
        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
             64'h0000_0000_0001_0000, 1'b0, 1'b0, "ripple");
        wait_done("ripple");

        // Full wrap: carry must propagate through every slice.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, "wrap");
        check("wrap_slice0_add_a", W'(bus.add_a), W'(16'hFFFF));
        check("wrap_slice0_add_cin", W'(bus.add_cin), W'(0));
        for (int k = 1; k < NWORDS; k++) begin
            @(negedge clk);
            check($sformatf("wrap_slice%0d_add_cin", k), W'(bus.add_cin), W'(1));
        end
        wait_done("wrap");

        // Signed overflow.
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, "ovf");
        wait_done("ovf");

        // Carry-in on its own.
        send(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b1, 1'b0,
             64'h0000_0000_0000_0031, 1'b0, 1'b0, "cin");
        wait_done("cin");

        // Subtract 5 - 7.
`ifdef ADDSEQ_SUB_EN
        send(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub");
`else
        send(64'd5, 64'd7, 1'b0, 1'b1, 64'hC, 1'b0, 1'b0, "sub");
`endif
        wait_done("sub");

        // Backpressure: hold out_ready low for 3 DONE cycles with a second request waiting.
        bus.out_ready = 1'b0;
        send(64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
             64'h2222_3333_4444_5555, 1'b0, 1'b0, "bp1");
        begin
            int n = 0;
            while (!bus.out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_hold%0d_valid", k), W'(bus.out_valid), W'(1));
            check($sformatf("bp_hold%0d_sum", k), bus.out_sum, 64'h2222_3333_4444_5555);
            check($sformatf("bp_hold%0d_in_ready", k), W'(bus.in_ready), W'(0));
            if (k == 0) begin
                bus.in_a = 64'h0000_0000_0000_8000; bus.in_b = 64'h0000_0000_0000_8000;
                bus.in_cin = 1'b0; bus.in_sub = 1'b0; bus.in_valid = 1'b1;
            end
            if (k < 2) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_after_hs_valid", W'(bus.out_valid), W'(0));
        check("bp_after_hs_in_ready", W'(bus.in_ready), W'(1));
        if (bus.in_ready) push_exp(64'h0000_0000_0001_0000, 1'b0, 1'b0, cyc + 1, "bp2");
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done("bp2");

        // Reset abort while processing slice 2.
        send(64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 1'b0, 1'b0,
             64'h0003_0003_0003_0003, 1'b0, 1'b0, "abort");
        repeat (2) @(negedge clk);
        check("abort_idx2_add_b", W'(bus.add_b), W'(16'h0002));
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_out_valid", W'(bus.out_valid), W'(0));
        check("abort_in_ready", W'(bus.in_ready), W'(1));
        check("abort_add_a", W'(bus.add_a), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0, "post_abort");
        wait_done("post_abort");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
